rs232_recv: RTL and testbench

UART receive endpoint: deserializes 8N1 frames arriving on the RS232 TXD line into bytes and offers them on a valid/ready stream. It is the receive-direction counterpart of the team's `rs232_send3` transmitter and sits between the board RS232 pins and the fabric logic. A small internal FIFO absorbs bursts, and hardware flow control is driven on CTS# so the host pauses before the FIFO overflows.

---
 rtl/rs232_recv.sv | 148 ++++++++++++++
 tb/tb_rs232_recv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rs232_recv.sv
// 8N1 UART receiver with a small byte FIFO, valid/ready output stream and CTS# flow control.
// Define RS232_RECV_FRAMING_ERR_EN to add the framing_error pulse output.
module rs232_recv #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000,
  parameter int DEPTH_LOG2 = 4,
  parameter int SLACK      = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rs232_txd,
  output logic       rs232_ctsn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
`ifdef RS232_RECV_FRAMING_ERR_EN
  , output logic     framing_error
`endif
);

  localparam int BIT   = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF  = BIT / 2;
  localparam int CW    = $clog2(BIT);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] SLACK_W = (DEPTH_LOG2 + 1)'(SLACK);

  // Handshake: a byte transfers on every cycle where valid and ready are both
  // high; data holds steady while valid is high and ready is low.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      sync_q;
  logic            rxs;
  logic            tick;
  logic            push;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rs232_txd};
  end

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = CW'(HALF - 1);
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs) begin
          cnt_d   = CW'(BIT - 1);
          bit_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d = {rxs, shreg_q[7:1]};
          cnt_d   = CW'(BIT - 1);
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          push    = rxs;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: pointers carry one extra bit so full and empty are distinguishable.
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_q, rd_q, count, free;
  logic                full, push_ok, pop;

  assign count   = wr_q - rd_q;
  assign free    = DEPTH_W - count;
  assign full    = (count == DEPTH_W);
  assign valid   = (wr_q != rd_q);
  assign push_ok = push && !full;
  assign pop     = valid && ready;
  assign data    = valid ? mem[rd_q[DEPTH_LOG2-1:0]] : 8'h00;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_q[DEPTH_LOG2-1:0]] <= shreg_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q       <= '0;
      rd_q       <= '0;
      rs232_ctsn <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      rs232_ctsn <= (free <= SLACK_W);
    end
  end

`ifdef RS232_RECV_FRAMING_ERR_EN
  // Bad stop bit or a byte lost to a full FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) framing_error <= 1'b0;
    else         framing_error <= (state_q == STOP && tick && !rxs) || (push && full);
  end
`endif

endmodule

// File: tb/tb_rs232_recv.sv
// Directed bench for rs232_recv: frames driven at 11 clocks/bit, bytes checked via an expected queue.
module tb_rs232_recv;

  localparam int BIT = 11;

  logic       clock;
  logic       resetn;
  logic       rs232_txd;
  logic       rs232_ctsn;
  logic [7:0] data;
  logic       valid;
  logic       ready;
`ifdef RS232_RECV_FRAMING_ERR_EN
  logic       framing_error;
`endif

  rs232_recv dut (
    .clock      (clock),
    .resetn     (resetn),
    .rs232_txd  (rs232_txd),
    .rs232_ctsn (rs232_ctsn),
    .data       (data),
    .valid      (valid),
    .ready      (ready)
`ifdef RS232_RECV_FRAMING_ERR_EN
    , .framing_error (framing_error)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int start_cyc = 0;
  int rise_cyc = 0;
  int valid_cycles = 0;
  int fe_cycles = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic v);
    rs232_txd = v;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clock);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rs232_txd = 1'b1;
    repeat (20) @(posedge clock);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (valid && !valid_prev) rise_cyc = cyc;
    if (valid) valid_cycles++;
    valid_prev = valid;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        check("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
`ifdef RS232_RECV_FRAMING_ERR_EN
    if (framing_error) fe_cycles++;
`endif
  end

  initial begin
    logic [1:0] st;
    logic [7:0] b;
    resetn    = 1'b0;
    rs232_txd = 1'b1;
    ready     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", {31'h0, valid}, 32'd0);
    check("rst_ctsn", {31'h0, rs232_ctsn}, 32'd1);
    check("rst_data", {24'h0, data}, 32'h00);
    resetn = 1'b1;
    @(negedge clock);
    check("ctsn_after_release", {31'h0, rs232_ctsn}, 32'd0);
    check("idle_valid", {31'h0, valid}, 32'd0);
    check("idle_data", {24'h0, data}, 32'h00);

    // single byte, latency and one-cycle valid with ready held high
    ready = 1'b1;
    valid_cycles = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_latency", rise_cyc - start_cyc, 32'd107);
    check("a5_valid_cycles", valid_cycles, 32'd1);

    // 3-cycle glitch must not start a frame
    @(posedge clock);
    #1;
    rs232_txd = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rs232_txd = 1'b1;
    repeat (15) @(posedge clock);
    @(negedge clock);
    st = dut.state_q;
    check("glitch_idle", {30'h0, st}, 32'd0);
    check("glitch_no_byte", valid_cycles, 32'd1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);

    // bad stop bit: byte discarded
    send_frame(8'h55, 1'b0);
    check("bad_stop_no_byte", valid_cycles, 32'd2);
`ifdef RS232_RECV_FRAMING_ERR_EN
    check("bad_stop_fe_pulse", fe_cycles, 32'd1);
`endif

    // fill FIFO with ready low, observe CTS# and overflow drop
    ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      b = 8'(i);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    check("ctsn_5_free", {31'h0, rs232_ctsn}, 32'd0);
    exp_q.push_back(8'h0B);
    send_frame(8'h0B, 1'b1);
    check("ctsn_4_free", {31'h0, rs232_ctsn}, 32'd1);
    for (int i = 12; i < 17; i++) begin
      b = 8'(i);
      if (i < 16) exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    @(negedge clock);
    check("full_ctsn", {31'h0, rs232_ctsn}, 32'd1);
    check("head_hold", {24'h0, data}, 32'h00);
    check("full_valid", {31'h0, valid}, 32'd1);
`ifdef RS232_RECV_FRAMING_ERR_EN
    check("drop_fe_pulse", fe_cycles, 32'd2);
`endif
    @(posedge clock);
    #1;
    ready = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_ctsn", {31'h0, rs232_ctsn}, 32'd0);

    // reset during data bit 4 aborts the frame
    @(posedge clock);
    #1;
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rs232_txd = b[4];
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    rs232_txd = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    st = dut.state_q;
    check("post_reset_idle", {30'h0, st}, 32'd0);
    check("post_reset_valid", {31'h0, valid}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    @(negedge clock);
    check("final_queue_empty", exp_q.size(), 32'd0);
`ifdef RS232_RECV_FRAMING_ERR_EN
    check("final_fe_count", fe_cycles, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
